mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter TIMEOUT, default 255, maximum number of cycles to wait for mem_ack before forcing completion (range 1..255).
REQ-003 clock  in  1  sole clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction fetch request; held high until if_ready is seen.
REQ-006 if_addr  in  ADDR_W  fetch address; stable while if_req is high.
REQ-007 if_flush  in  1  taken branch or jump; discards any in-flight fetch result.
REQ-008 if_rdata  out  32  fetch data; valid only while if_ready is high.
REQ-009 if_ready  out  1  one-cycle fetch completion pulse.
REQ-010 d_req  in  1  data request; held high until d_ready is seen.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  ADDR_W  data address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_be  in  4  store byte enables.
REQ-015 d_rdata  out  32  load data; valid only while d_ready is high.
REQ-016 d_ready  out  1  one-cycle data completion pulse.
REQ-017 mem_req  out  1  shared-bus request.
REQ-018 mem_we  out  1  shared-bus write enable.
REQ-019 mem_addr  out  ADDR_W  shared-bus address.
REQ-020 mem_wdata  out  32  shared-bus write data.
REQ-021 mem_be  out  4  shared-bus byte enables.
REQ-022 mem_rdata  in  32  shared-bus read data; valid when mem_ack is high.
REQ-023 mem_ack  in  1  shared-bus completion.
REQ-024 mem_busy  out  1  high whenever state is not IDLE; feeds stall control as the inverted memReady.
REQ-025 timeout_err  out  1  sticky timeout flag.

Function
REQ-026 FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
REQ-027 IDLE with only if_req high -> BUSY_I; with only d_req high -> BUSY_D; with neither high -> remain in IDLE.
REQ-028 IDLE with both requests high -> grant the port not granted last; the last-grant register resets to "fetch", so data wins the first tie.
REQ-029 On entry to BUSY_x, latch the granted port's address, we, wdata and be into registers; mem_* outputs are driven only from these registers.
REQ-030 Fetch grants drive mem_we = 0 and mem_be = 4'b1111.
REQ-031 mem_req is high for every cycle of BUSY_I/BUSY_D and low in all other states.
REQ-032 On mem_ack in BUSY_x, capture mem_rdata and move to DONE_x.
REQ-033 Latency from mem_ack to the ready pulse is one cycle; with a same-cycle ack, the minimum request-to-ready latency is 2 cycles.
REQ-034 DONE_x asserts x_ready for exactly one cycle, then returns to IDLE; requests are not sampled in DONE_x.
REQ-035 Requesters drop req at the edge ending the ready cycle, so there is no re-grant of a stale request.
REQ-036 If if_flush is high in BUSY_I (any cycle) or in DONE_I, set a discard flag.
REQ-037 A discarded fetch still completes on the bus, but if_ready is held low in DONE_I; the flag clears on leaving DONE_I.
REQ-038 if_flush has no effect on data transactions.
REQ-039 d_rdata is forced to 0 for stores.
REQ-040 An 8-bit wait counter clears on entry to BUSY_x and increments each BUSY cycle without mem_ack.
REQ-041 When the wait counter reaches TIMEOUT without mem_ack: go to DONE_x with captured rdata = 32'h0 and set timeout_err.
REQ-042 mem_ack arriving in the same cycle as the timeout takes precedence: normal completion, no error.
REQ-043 mem_ack arriving in IDLE or DONE_x is ignored.
REQ-044 if_rdata and d_rdata are 0 whenever their ready signal is low.

Reset
REQ-045 Reset forces state IDLE, last-grant = fetch, and clears the discard flag, wait counter and timeout_err.
REQ-046 During reset, all outputs are 0 on the following cycle.
REQ-047 Reset mid-transaction abandons it with no ready pulse; the bus is expected to be reset alongside.
REQ-048 timeout_err clears only on reset.

Verification
REQ-049 Fetch only: if_addr=0x100, mem_ack 1 cycle after mem_req -> mem_addr=0x100, mem_we=0, if_ready pulses once with rdata from bus, then IDLE.
REQ-050 Simultaneous if_req and d_req after reset -> data served first, then fetch; repeat the tie -> the order alternates.
REQ-051 Store: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF -> bus shows the same values, d_ready pulses, d_rdata=0.
REQ-052 if_flush in the 2nd BUSY_I cycle -> bus completes, no if_ready; the following d_req is granted normally.
REQ-053 TIMEOUT=4, mem_ack never asserted -> DONE after 4 BUSY cycles, d_rdata=0, timeout_err=1 until reset.
REQ-054 Reset asserted during BUSY_D -> mem_req=0, mem_busy=0, d_ready never pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory bus, with fair tie-break,
// fetch discard on flush, a per-transaction wait timeout and a sticky timeout flag.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state_r;
  logic       last_data_r;
  logic       discard_r;
  logic [7:0] wait_cnt_r;
  logic       timeout_hit_s;
  logic       discard_now_s;

  // A flush in the final BUSY_I cycle must still suppress the ready pulse.
  assign timeout_hit_s = !mem_ack && (wait_cnt_r == LAST_WAIT);
  assign discard_now_s = discard_r | if_flush;

  // Arbitration FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      last_data_r <= 1'b0;
      discard_r   <= 1'b0;
      wait_cnt_r  <= 8'd0;
      timeout_err <= 1'b0;
      mem_req     <= 1'b0;
      mem_busy    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_wdata   <= 32'h0;
      mem_be      <= 4'h0;
      if_ready    <= 1'b0;
      if_rdata    <= 32'h0;
      d_ready     <= 1'b0;
      d_rdata     <= 32'h0;
    end else begin
      if_ready <= 1'b0;
      if_rdata <= 32'h0;
      d_ready  <= 1'b0;
      d_rdata  <= 32'h0;
      case (state_r)
        IDLE: begin
          if (d_req && (!if_req || !last_data_r)) begin
            state_r     <= BUSY_D;
            last_data_r <= 1'b1;
            mem_req     <= 1'b1;
            mem_busy    <= 1'b1;
            wait_cnt_r  <= 8'd0;
            mem_we      <= d_we;
            mem_addr    <= d_addr;
            mem_wdata   <= d_wdata;
            mem_be      <= d_be;
          end else if (if_req) begin
            state_r     <= BUSY_I;
            last_data_r <= 1'b0;
            mem_req     <= 1'b1;
            mem_busy    <= 1'b1;
            wait_cnt_r  <= 8'd0;
            mem_we      <= 1'b0;
            mem_addr    <= if_addr;
            mem_wdata   <= 32'h0;
            mem_be      <= 4'hF;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY_I: begin
          if (if_flush) begin
            discard_r <= 1'b1;
          end
          if (mem_ack || timeout_hit_s) begin
            state_r <= DONE_I;
            mem_req <= 1'b0;
            if (!discard_now_s) begin
              if_ready <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : 32'h0;
            end
            if (!mem_ack) begin
              timeout_err <= 1'b1;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        BUSY_D: begin
          if (mem_ack || timeout_hit_s) begin
            state_r <= DONE_D;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            d_rdata <= (mem_ack && !mem_we) ? mem_rdata : 32'h0;
            if (!mem_ack) begin
              timeout_err <= 1'b1;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        DONE_I: begin
          state_r   <= IDLE;
          mem_busy  <= 1'b0;
          discard_r <= 1'b0;
        end
        DONE_D: begin
          state_r  <= IDLE;
          mem_busy <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          mem_req   <= 1'b0;
          mem_busy  <= 1'b0;
          discard_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grant order,
// bus contents, completion cycle, ready data and the sticky timeout flag.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0, if_flush = 1'b0, if_ready;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0, d_ready;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = 32'h0, d_rdata;
  logic [3:0]    d_be = 4'h0;
  logic          mem_req, mem_we, mem_busy, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata = 32'h0;
  logic [3:0]    mem_be;
  logic          mem_ack = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit last_data = 1'b0;
  bit exp_terr = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_busy(mem_busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check_val({tag, "_mem_busy"}, 32'(mem_busy), 32'd0);
    check_val({tag, "_if_ready"}, 32'(if_ready), 32'd0);
    check_val({tag, "_d_ready"}, 32'(d_ready), 32'd0);
    check_val({tag, "_if_rdata"}, if_rdata, 32'h0);
    check_val({tag, "_d_rdata"}, d_rdata, 32'h0);
    check_val({tag, "_terr"}, 32'(timeout_err), 32'(exp_terr));
  endtask

  // Serve one grant. Entry: sample point of an IDLE cycle with requests already driven.
  task automatic serve_one(input int ack_k, input int flush_k);
    bit          g_data, discard, tmo;
    logic [31:0] e_addr, e_wdata, rdata, e_r;
    logic        e_we;
    logic [3:0]  e_be;
    g_data  = d_req && (!if_req || !last_data);
    e_addr  = g_data ? d_addr : if_addr;
    e_we    = g_data ? d_we : 1'b0;
    e_be    = g_data ? d_be : 4'hF;
    e_wdata = d_wdata;
    discard = 1'b0;
    tmo     = 1'b0;
    rdata   = 32'h0;
    for (int k = 1; k <= TO; k++) begin
      @(posedge clock); #1;
      check_val("busy_mem_req", 32'(mem_req), 32'd1);
      check_val("busy_mem_busy", 32'(mem_busy), 32'd1);
      check_val("busy_mem_addr", mem_addr, e_addr);
      check_val("busy_mem_we", 32'(mem_we), 32'(e_we));
      check_val("busy_mem_be", 32'(mem_be), 32'(e_be));
      if (g_data) check_val("busy_mem_wdata", mem_wdata, e_wdata);
      check_val("busy_if_ready", 32'(if_ready), 32'd0);
      check_val("busy_d_ready", 32'(d_ready), 32'd0);
      mem_rdata = $urandom;
      mem_ack   = (k == ack_k);
      if_flush  = (k == flush_k);
      if (!g_data && if_flush) discard = 1'b1;
      if (mem_ack) begin
        rdata = mem_rdata;
        break;
      end
      if (k == TO) tmo = 1'b1;
    end
    @(posedge clock); #1;
    if (tmo) exp_terr = 1'b1;
    e_r = (tmo || (g_data && e_we)) ? 32'h0 : rdata;
    if (g_data) begin
      check_val("done_d_ready", 32'(d_ready), 32'd1);
      check_val("done_d_rdata", d_rdata, e_r);
      check_val("done_if_ready", 32'(if_ready), 32'd0);
      check_val("done_if_rdata", if_rdata, 32'h0);
    end else begin
      check_val("done_if_ready", 32'(if_ready), 32'(!discard));
      check_val("done_if_rdata", if_rdata, discard ? 32'h0 : e_r);
      check_val("done_d_ready", 32'(d_ready), 32'd0);
      check_val("done_d_rdata", d_rdata, 32'h0);
    end
    check_val("done_mem_req", 32'(mem_req), 32'd0);
    check_val("done_mem_busy", 32'(mem_busy), 32'd1);
    check_val("done_terr", 32'(timeout_err), 32'(exp_terr));
    if (g_data) d_req = 1'b0;
    else if_req = 1'b0;
    if_flush  = 1'b0;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    last_data = g_data;
    @(posedge clock); #1;
    check_idle("idle");
    mem_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic serve_all(input int ack_k, input int flush_k);
    serve_one(ack_k, flush_k);
    if (if_req || d_req) serve_one($urandom_range(1, TO), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_idle("reset");
    check_val("reset_mem_addr", mem_addr, 32'h0);
    check_val("reset_mem_we", 32'(mem_we), 32'd0);
    check_val("reset_mem_wdata", mem_wdata, 32'h0);
    check_val("reset_mem_be", 32'(mem_be), 32'd0);
    reset = 1'b0;

    // Fetch only, ack one cycle after mem_req rises.
    if_req = 1'b1; if_addr = 32'h100;
    serve_all(2, 0);

    // Ties alternate between the ports.
    repeat (2) begin
      if_req = 1'b1; if_addr = $urandom;
      d_req = 1'b1; d_we = 1'b0; d_addr = $urandom; d_be = 4'hF;
      serve_all(1, 0);
    end

    // Store: bus carries the store, d_rdata stays 0.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 32'h2000;
    serve_all(1, 0);

    // Flushed fetch, then an ordinary load.
    if_req = 1'b1; if_addr = 32'h300;
    serve_all(3, 2);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    serve_all(1, 0);

    repeat (40) begin
      if_req = 1'($urandom_range(0, 1));
      d_req  = 1'($urandom_range(0, 1));
      if (!if_req && !d_req) if_req = 1'b1;
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
      serve_all($urandom_range(1, TO), $urandom_range(0, TO));
    end

    // Ack on the timeout cycle wins; one cycle later is a timeout.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    serve_all(TO, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    serve_all(TO + 1, 0);
    if_req = 1'b1; if_addr = 32'h700;
    serve_all(1, 0);

    // Reset in the middle of a data transaction.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    @(posedge clock); #1;
    check_val("rst_busy_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    exp_terr = 1'b0; last_data = 1'b0;
    check_idle("rst_mid");
    d_req = 1'b0; reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      check_idle("post_rst");
    end
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h900; d_addr = 32'hA00;
    serve_all(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
